// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
//   state_e     - sequencer states (IDLE, RUN, HALT)
//   TABLE_DEPTH - number of branch-target table entries
//   IDX_W       - width of a table index
package pc_seq_pkg;

    localparam int unsigned TABLE_DEPTH = 16;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_target_table.sv
// pc_target_table: 16-entry branch-target table, one synchronous write port and
// one combinational read port. Contents have no reset; they power up as zero.
//   clk   - write clock (rising edge)
//   we    - write strobe
//   waddr - write index
//   wdata - write value
//   raddr - read index
//   rdata - combinational read of stored contents (a same-cycle write is not
//           visible until after the edge)
module pc_target_table
    import pc_seq_pkg::*;
#(
    parameter int unsigned D = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [D-1:0]     wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [D-1:0]     rdata
);

    logic [D-1:0] mem [TABLE_DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with IDLE/RUN/HALT control and a
// 16-entry branch-target table.
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   start                 - load START_PC and enter RUN (only from IDLE/HALT)
//   stall                 - hold pc for one RUN cycle
//   halt_req              - end-of-program instruction; enter HALT
//   branch_en             - take branch to table[target_sel]
//   target_sel, rel       - table index; rel=1 treats the entry as signed offset
//   cfg_we/addr/data      - table write port, accepted in every state
//   pc, busy, done        - registered program counter, RUN flag, HALT flag
// Optional feature: define PC_SEQ_REL_BRANCH_EN to enable relative branches.
// Without it rel is ignored and every taken branch is absolute.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned D        = 10,
    parameter int unsigned START_PC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch_en,
    input  logic [IDX_W-1:0] target_sel,
    input  logic             rel,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [D-1:0]     cfg_data,
    output logic [D-1:0]     pc,
    output logic             busy,
    output logic             done
);

    localparam logic [D-1:0] START_VAL = D'(START_PC);

    state_e       state_q;
    logic [D-1:0] pc_q;
    logic         busy_q;
    logic         done_q;
    logic [D-1:0] tbl_rdata;
    logic [D-1:0] branch_pc;

    pc_target_table #(
        .D (D)
    ) u_table (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (target_sel),
        .rdata (tbl_rdata)
    );

`ifdef PC_SEQ_REL_BRANCH_EN
    // Unsigned add of the raw entry equals the two's-complement add mod 2^D.
    always_comb begin
        branch_pc = tbl_rdata;
        if (rel) begin
            branch_pc = pc_q + tbl_rdata;
        end
    end
`else
    logic unused_rel;
    assign unused_rel = rel;
    assign branch_pc  = tbl_rdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_VAL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, HALT: begin
                    if (start) begin
                        state_q <= RUN;
                        pc_q    <= START_VAL;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state_q <= HALT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (!stall) begin
                        if (branch_en) begin
                            pc_q <= branch_pc;
                        end else begin
                            pc_q <= pc_q + D'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pc   = pc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed, table-driven bench for pc_seq (D=10, START_PC=0),
// with hand-written sequences for relative branches, wrap and async reset.
module tb_pc_seq;

    localparam int unsigned D = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, stall, halt_req, branch_en, rel, cfg_we;
    logic [3:0]   target_sel, cfg_addr;
    logic [D-1:0] cfg_data;
    logic [D-1:0] pc;
    logic         busy, done;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic         start, stall, halt_req, branch_en;
        logic [3:0]   sel;
        logic         rel, we;
        logic [3:0]   addr;
        logic [D-1:0] data;
        logic [D-1:0] exp_pc;
        logic         exp_busy, exp_done;
    } vec_t;

    vec_t vecs[$];

    pc_seq #(
        .D        (D),
        .START_PC (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .halt_req   (halt_req),
        .branch_en  (branch_en),
        .target_sel (target_sel),
        .rel        (rel),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int epc, input int ebusy, input int edone);
        check({name, " pc"}, int'(pc), epc);
        check({name, " busy"}, int'(busy), ebusy);
        check({name, " done"}, int'(done), edone);
    endtask

    task automatic addv(input int s, input int st, input int h, input int b, input int sel,
                        input int r, input int we, input int a, input int dat,
                        input int epc, input int ebusy, input int edone);
        vec_t v;
        v.start = 1'(s);      v.stall = 1'(st);   v.halt_req = 1'(h);  v.branch_en = 1'(b);
        v.sel = 4'(sel);      v.rel = 1'(r);      v.we = 1'(we);       v.addr = 4'(a);
        v.data = D'(dat);     v.exp_pc = D'(epc); v.exp_busy = 1'(ebusy);
        v.exp_done = 1'(edone);
        vecs.push_back(v);
    endtask

    task automatic drive(input int s, input int st, input int h, input int b, input int sel,
                         input int r, input int we, input int a, input int dat);
        start = 1'(s);   stall = 1'(st);  halt_req = 1'(h);  branch_en = 1'(b);
        target_sel = 4'(sel);  rel = 1'(r);  cfg_we = 1'(we);  cfg_addr = 4'(a);
        cfg_data = D'(dat);
    endtask

    // Apply inputs at the falling edge, let one rising edge pass, sample at the next fall.
    task automatic step(input int s, input int st, input int h, input int b, input int sel,
                        input int r, input int we, input int a, input int dat);
        drive(s, st, h, b, sel, r, we, a, dat);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int rel_exp;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_out("reset", 0, 0, 0);

        //   start stall halt br sel rel we addr data  | pc busy done
        addv(1, 0, 0, 0, 0, 0, 0, 0,  0,    0, 1, 0); // start -> 0
        addv(0, 0, 0, 0, 0, 0, 0, 0,  0,    1, 1, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0,  0,    2, 1, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0,  0,    3, 1, 0);
        addv(0, 0, 0, 0, 0, 0, 1, 2, 80,    4, 1, 0); // table[2]=80
        addv(0, 0, 0, 0, 0, 0, 0, 0,  0,    5, 1, 0);
        addv(0, 0, 0, 1, 2, 0, 0, 0,  0,   80, 1, 0); // absolute branch at pc=5
        addv(0, 0, 0, 0, 0, 0, 0, 0,  0,   81, 1, 0);
        addv(0, 1, 0, 0, 0, 0, 0, 0,  0,   81, 1, 0); // stall
        addv(0, 1, 0, 1, 2, 0, 0, 0,  0,   81, 1, 0); // stall beats branch
        addv(1, 0, 0, 0, 0, 0, 0, 0,  0,   82, 1, 0); // start ignored in RUN
        addv(0, 0, 0, 1, 5, 0, 1, 5, 40,    0, 1, 0); // write+branch same entry: old value 0
        addv(0, 0, 0, 1, 5, 0, 0, 0,  0,   40, 1, 0);
        addv(0, 0, 1, 1, 2, 0, 0, 0,  0,   40, 0, 1); // halt beats branch
        addv(0, 1, 1, 1, 2, 0, 0, 0,  0,   40, 0, 1); // ignored in HALT
        addv(0, 0, 0, 0, 0, 0, 1, 3, 20,   40, 0, 1); // table write in HALT
        addv(1, 0, 0, 0, 0, 0, 0, 0,  0,    0, 1, 0); // restart
        addv(0, 0, 0, 0, 0, 0, 1, 9, 1020,  1, 1, 0); // table[9] = -4
        addv(0, 0, 0, 1, 3, 0, 0, 0,  0,   20, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].stall, vecs[i].halt_req, vecs[i].branch_en,
                 vecs[i].sel, vecs[i].rel, vecs[i].we, vecs[i].addr, vecs[i].data);
            check_out($sformatf("vec%0d", i), int'(vecs[i].exp_pc), int'(vecs[i].exp_busy),
                      int'(vecs[i].exp_done));
        end

        // Relative branches; with the feature disabled rel is ignored.
`ifdef PC_SEQ_REL_BRANCH_EN
        rel_exp = 16;
`else
        rel_exp = 1020;
`endif
        step(0, 0, 0, 1, 9, 1, 0, 0, 0);
        check_out("rel back", rel_exp, 1, 0);
        step(0, 1, 0, 0, 0, 0, 1, 4, 2);
        step(0, 1, 0, 0, 0, 0, 1, 9, 1019);
        step(0, 0, 0, 1, 4, 0, 0, 0, 0);
        check_out("abs to 2", 2, 1, 0);
`ifdef PC_SEQ_REL_BRANCH_EN
        rel_exp = 1021;
`else
        rel_exp = 1019;
`endif
        step(0, 0, 0, 1, 9, 1, 0, 0, 0);
        check_out("rel wrap", rel_exp, 1, 0);

        // Increment wrap from 1023.
        step(0, 1, 0, 0, 0, 0, 1, 6, 1023);
        step(0, 0, 0, 1, 6, 0, 0, 0, 0);
        check_out("at 1023", 1023, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out("inc wrap", 0, 1, 0);

        // Async reset between edges at pc=37 with a branch pending.
        step(0, 1, 0, 0, 0, 0, 1, 7, 37);
        step(0, 0, 0, 1, 7, 0, 0, 0, 0);
        check_out("at 37", 37, 1, 0);
        drive(0, 0, 0, 1, 2, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1 check_out("async reset", 0, 0, 0);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_out("branch abandoned", 0, 0, 0);
        step(0, 1, 1, 1, 7, 0, 0, 0, 0);
        check_out("idle ignores", 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out("start after reset", 0, 1, 0);
        step(0, 0, 0, 1, 7, 0, 0, 0, 0);
        check_out("table kept", 37, 1, 0);
        step(0, 0, 0, 1, 2, 0, 0, 0, 0);
        check_out("table kept 2", 80, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter D, default 10: program-counter and branch-target width in bits.
REQ-002 Parameter START_PC, default 0: PC value loaded on reset and on every start.
REQ-003 Port clk, input, 1: single clock, rising-edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: begin execution from START_PC; honoured only in IDLE or HALT.
REQ-006 Port stall, input, 1: hold PC for this cycle while in RUN.
REQ-007 Port halt_req, input, 1: the current instruction is the end-of-program instruction.
REQ-008 Port branch_en, input, 1: the current instruction's branch is taken.
REQ-009 Port target_sel, input, 4: index into the 16-entry branch-target table.
REQ-010 Port rel, input, 1: 1 means the table entry is a signed offset; 0 means it is an absolute target.
REQ-011 Port cfg_we, input, 1: write strobe for the branch-target table.
REQ-012 Port cfg_addr, input, 4: index of the table entry to write.
REQ-013 Port cfg_data, input, D: value to write into the table.
REQ-014 Port pc, output, D: registered program counter.
REQ-015 Port busy, output, 1: high when the state is RUN.
REQ-016 Port done, output, 1: registered; high when the state is HALT.

Function
REQ-017 The block SHALL implement a three-state machine: IDLE, RUN, HALT.
REQ-018 In IDLE, pc SHALL hold its value; start SHALL move the state to RUN and load pc=START_PC on the same edge.
REQ-019 In RUN, per-cycle priority SHALL be: halt_req, then stall, then branch_en, then increment.
- halt_req: next state HALT; pc held.
- stall: pc held.
- branch_en, rel=0: pc = table[target_sel].
- branch_en, rel=1: pc = (pc + table[target_sel]), with the entry read as two's complement, modulo 2^D.
- otherwise: pc = (pc + 1) modulo 2^D.
REQ-020 Every PC update SHALL take effect on the edge that samples its controls, i.e. one cycle of latency.
REQ-021 In RUN, start SHALL be ignored.
REQ-022 In IDLE and HALT, branch_en, stall and halt_req SHALL be ignored.
REQ-023 In HALT, pc SHALL hold and done=1; start SHALL return the state to RUN, load pc=START_PC and clear done on that edge.
REQ-024 The table SHALL have 16 entries of D bits.
REQ-025 Table writes SHALL occur on the clock edge; reads SHALL be combinational from stored contents.
REQ-026 A write and a branch to the same entry in the same cycle SHALL use the old entry value.
REQ-027 Table writes SHALL be accepted in every state.
REQ-028 Increment from 2^D-1 SHALL wrap to 0, and relative overflow SHALL wrap modulo 2^D, with no error flag.

Reset
REQ-029 Asserting reset SHALL immediately, without waiting for clk, set state=IDLE, pc=START_PC, busy=0 and done=0.
REQ-030 Reset SHALL NOT alter table contents.
REQ-031 Table power-up contents SHALL be 0.
REQ-032 Reset asserted mid-RUN SHALL abandon any pending branch.

Configuration
REQ-033 The relative-branch feature SHALL be controlled by macro PC_SEQ_REL_BRANCH_EN.
- Defined: rel behaves per REQ-019.
- Undefined: rel is ignored, every taken branch is absolute, and no adder for pc+offset is built.

Structure
REQ-034 Package pc_seq_pkg SHALL hold the state enum (IDLE, RUN, HALT), the table depth constant (16) and the index width (4).
REQ-035 The table SHALL be a sub-module pc_target_table with one write port and one combinational read port.
REQ-036 The FSM and PC register SHALL live in pc_seq.

Verification
REQ-037 Reset and sequencing: reset, then start; then 3 idle RUN cycles -> pc = 0, 1, 2, 3 and busy=1.
REQ-038 Absolute branch: write table[2]=80; at pc=5 assert branch_en, target_sel=2, rel=0 -> pc=80 next cycle.
REQ-039 Relative branch and wrap (macro defined): table[9]=1020 (-4); at pc=20 with rel=1 -> pc=16; table[9]=1019 at pc=2 -> pc=1021.
REQ-040 Priority and restart: halt_req and branch_en together at pc=40 -> HALT, pc=40, done=1; then start -> pc=0, done=0, RUN.
REQ-041 Increment wrap: pc=1023 with no controls -> pc=0.
REQ-042 Async reset mid-operation: reset pulsed between edges at pc=37 in RUN -> pc=0, IDLE, busy=0 before the next edge; table contents unchanged.
